// File: rtl/addsub_tree_pipe_pkg.sv
// Shared helpers for signed add/subtract trees: internal width, level sizing and saturation.
// The clamp helpers work on a 64-bit container so accumulators of any supported width can share them.
package addsub_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t lo;
    wide_t hi;
  } clamp_lim_t;

  function automatic int ext_w(input int width, input int n);
    return width + $clog2(n) + 1;
  endfunction

  // number of live terms after l pairwise levels
  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  function automatic clamp_lim_t clamp_lim(input int width);
    clamp_lim_t r;
    r.hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    r.lo = -(wide_t'(1) <<< (width - 1));
    return r;
  endfunction

  function automatic wide_t sat_clamp(input wide_t s, input int width);
    clamp_lim_t r;
    r = clamp_lim(width);
    if ($signed(s) > $signed(r.hi)) return r.hi;
    if ($signed(s) < $signed(r.lo)) return r.lo;
    return s;
  endfunction

endpackage

// File: rtl/addsub_tree_pipe_if.sv
// Operand/result handshake bundle for addsub_tree_pipe.
// The master side is the producer/consumer pair; the slave side is the tree.
interface addsub_tree_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] ops;
  logic [N-1:0]       neg;
  logic               sat;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   f;
  logic               ovf;

  modport master (
    output in_valid, ops, neg, sat, out_ready,
    input  in_ready, out_valid, f, ovf
  );

  modport slave (
    input  in_valid, ops, neg, sat, out_ready,
    output in_ready, out_valid, f, ovf
  );
endinterface

// File: rtl/addsub_tree_pipe_level.sv
// One registered level of the adder tree: NIN terms in, ceil(NIN/2) pairwise sums out.
// An odd last term is carried through unchanged, which is the same as adding a zero operand.
module add_tree_level #(
  parameter  int EXT  = 8,
  parameter  int NIN  = 2,
  localparam int NOUT = (NIN + 1) / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_sat,
  input  logic [NIN*EXT-1:0]  in_d,
  output logic                out_valid,
  output logic                out_sat,
  output logic [NOUT*EXT-1:0] out_d
);

  logic [NOUT*EXT-1:0] sum;

  genvar j;
  generate
    for (j = 0; j < NOUT; j++) begin : g_pair
      if (2 * j + 1 < NIN) begin : g_add
        assign sum[j*EXT +: EXT] = in_d[2*j*EXT +: EXT] + in_d[(2*j+1)*EXT +: EXT];
      end else begin : g_pass
        assign sum[j*EXT +: EXT] = in_d[2*j*EXT +: EXT];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out_d     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_sat   <= in_sat;
      out_d     <= sum;
    end
  end

endmodule

// File: rtl/addsub_tree_pipe.sv
// N-operand signed add/subtract with per-operand sign mask, pipelined as a binary tree.
// Latency LVL+2: negate stage, LVL sum levels, range/clamp stage; one global stall enable.
module addsub_tree_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_tree_pipe_if.slave bus
);

  localparam int EXT = ext_w(WIDTH, N);
  localparam int LVL = $clog2(N);

  logic             adv;
  logic [N*EXT-1:0] st0_n;
  logic [N*EXT-1:0] st0_d;
  logic             st0_v;
  logic             st0_s;
  logic signed [EXT-1:0] op_e;

  // the whole pipe moves together; a full output register with no taker freezes every stage
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // EXT carries one spare bit, so negating the most negative operand is exact
  always_comb begin
    st0_n = '0;
    op_e  = '0;
    for (int k = 0; k < N; k++) begin
      op_e = EXT'($signed(bus.ops[k*WIDTH +: WIDTH]));
      st0_n[k*EXT +: EXT] = bus.neg[k] ? -op_e : op_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_v <= 1'b0;
      st0_s <= 1'b0;
      st0_d <= '0;
    end else if (adv) begin
      st0_v <= bus.in_valid;
      st0_s <= bus.sat;
      st0_d <= st0_n;
    end
  end

  genvar l;
  generate
    for (l = 0; l <= LVL; l++) begin : g_lvl
      localparam int NCNT = lvl_cnt(N, l);
      logic [NCNT*EXT-1:0] d;
      logic                v;
      logic                s;
      if (l == 0) begin : g_src
        assign d = st0_d;
        assign v = st0_v;
        assign s = st0_s;
      end else begin : g_add
        add_tree_level #(
          .EXT (EXT),
          .NIN (lvl_cnt(N, l - 1))
        ) u_lvl (
          .clk       (clk),
          .rst_n     (rst_n),
          .en        (adv),
          .in_valid  (g_lvl[l-1].v),
          .in_sat    (g_lvl[l-1].s),
          .in_d      (g_lvl[l-1].d),
          .out_valid (v),
          .out_sat   (s),
          .out_d     (d)
        );
      end
    end
  endgenerate

  logic [EXT-1:0]   s_fin;
  logic             v_fin;
  logic             sat_fin;
  wide_t            s_w;
  wide_t            f_w;
  clamp_lim_t       lim;
  logic             ovf_n;
  logic [WIDTH-1:0] f_n;

  assign s_fin   = g_lvl[LVL].d;
  assign v_fin   = g_lvl[LVL].v;
  assign sat_fin = g_lvl[LVL].s;

  always_comb begin
    s_w   = wide_t'($signed(s_fin));
    lim   = clamp_lim(WIDTH);
    ovf_n = ($signed(s_w) > $signed(lim.hi)) || ($signed(s_w) < $signed(lim.lo));
    f_w   = sat_fin ? sat_clamp(s_w, WIDTH) : s_w;
    f_n   = WIDTH'(f_w);
  end

  // f/ovf only load on a valid result so they hold across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.f         <= '0;
      bus.ovf       <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= v_fin;
      if (v_fin) begin
        bus.f   <= f_n;
        bus.ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_addsub_tree_pipe.sv
// Directed and randomized checks of addsub_tree_pipe at WIDTH=8 for N=3, 4 and 5.
module tb_addsub_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  addsub_tree_pipe_if #(.WIDTH(8), .N(3)) i3 ();
  addsub_tree_pipe_if #(.WIDTH(8), .N(4)) i4 ();
  addsub_tree_pipe_if #(.WIDTH(8), .N(5)) i5 ();

  addsub_tree_pipe #(.WIDTH(8), .N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  addsub_tree_pipe #(.WIDTH(8), .N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  addsub_tree_pipe #(.WIDTH(8), .N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(i5.slave));

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // plain integer reference: signed sum, then range test, then clamp or wrap
  function automatic void model(input int w, input int n, input longint op[16],
                                input logic [15:0] ng, input logic st,
                                output longint fe, output longint ov);
    longint s, hi, lo, m;
    s = 0;
    for (int k = 0; k < n; k++) s += ng[k] ? -op[k] : op[k];
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ov = (s > hi || s < lo) ? 1 : 0;
    if (st) fe = (s > hi) ? hi : ((s < lo) ? lo : s);
    else begin
      m = s & ((longint'(1) << w) - 1);
      if (m > hi) m -= (longint'(1) << w);
      fe = m;
    end
  endfunction

  task automatic run3(input longint op[16], input logic [2:0] ng, input logic st,
                      output longint fo, output longint ov, output int lat);
    @(posedge clk); #1;
    i3.in_valid = 1'b1; i3.neg = ng; i3.sat = st; i3.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) i3.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    i3.in_valid = 1'b0;
    lat = 1;
    while (!i3.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    fo = longint'($signed(i3.f));
    ov = longint'(i3.ovf);
  endtask

  task automatic run4(input longint op[16], input logic [3:0] ng, input logic st,
                      output longint fo, output longint ov, output int lat);
    @(posedge clk); #1;
    i4.in_valid = 1'b1; i4.neg = ng; i4.sat = st; i4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) i4.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    i4.in_valid = 1'b0;
    lat = 1;
    while (!i4.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    fo = longint'($signed(i4.f));
    ov = longint'(i4.ovf);
  endtask

  task automatic run5(input longint op[16], input logic [4:0] ng, input logic st,
                      output longint fo, output longint ov, output int lat);
    @(posedge clk); #1;
    i5.in_valid = 1'b1; i5.neg = ng; i5.sat = st; i5.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) i5.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    i5.in_valid = 1'b0;
    lat = 1;
    while (!i5.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    fo = longint'($signed(i5.f));
    ov = longint'(i5.ovf);
  endtask

  longint op[16];
  longint fo, ov, fe, oe;
  int     lat;
  longint qf[$];
  longint qo[$];
  int     acc, got, cyc, stale;

  initial begin
    rst_n = 1'b0;
    i3.in_valid = 1'b0; i3.ops = '0; i3.neg = '0; i3.sat = 1'b0; i3.out_ready = 1'b1;
    i4.in_valid = 1'b0; i4.ops = '0; i4.neg = '0; i4.sat = 1'b0; i4.out_ready = 1'b1;
    i5.in_valid = 1'b0; i5.ops = '0; i5.neg = '0; i5.sat = 1'b0; i5.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) op[k] = 0;

    #2;
    chk("reset_out_valid", longint'(i3.out_valid), 0);
    chk("reset_f", longint'(i3.f), 0);
    chk("reset_ovf", longint'(i3.ovf), 0);
    chk("reset_in_ready", longint'(i3.in_ready), 1);
    chk("reset_out_valid_n5", longint'(i5.out_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // a - b - c
    op[0] = 10; op[1] = 3; op[2] = 2;
    run3(op, 3'b110, 1'b0, fo, ov, lat);
    chk("n3_sub_f", fo, 5); chk("n3_sub_ovf", ov, 0); chk("n3_latency", lat, 4);

    op[0] = -128; op[1] = 1; op[2] = 0;
    run3(op, 3'b110, 1'b0, fo, ov, lat);
    chk("n3_wrap_f", fo, 127); chk("n3_wrap_ovf", ov, 1);
    run3(op, 3'b110, 1'b1, fo, ov, lat);
    chk("n3_sat_f", fo, -128); chk("n3_sat_ovf", ov, 1);

    for (int k = 0; k < 5; k++) op[k] = 127;
    run5(op, 5'b00000, 1'b1, fo, ov, lat);
    chk("n5_sat_f", fo, 127); chk("n5_sat_ovf", ov, 1); chk("n5_latency", lat, 5);
    run5(op, 5'b00000, 1'b0, fo, ov, lat);
    chk("n5_wrap_f", fo, 123); chk("n5_wrap_ovf", ov, 1);

    for (int k = 0; k < 4; k++) op[k] = -128;
    run4(op, 4'b1111, 1'b1, fo, ov, lat);
    chk("n4_negmin_sat_f", fo, 127); chk("n4_negmin_ovf", ov, 1); chk("n4_latency", lat, 4);
    run4(op, 4'b1111, 1'b0, fo, ov, lat);
    chk("n4_negmin_wrap_f", fo, 0); chk("n4_negmin_wrap_ovf", ov, 1);

    // random traffic with bubbles and back-pressure against an in-order scoreboard
    acc = 0; got = 0; cyc = 0;
    while ((acc < 100 || qf.size() > 0) && cyc < 3000) begin
      @(posedge clk); #1;
      i3.in_valid = (acc < 100) && ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        op[k] = longint'($urandom_range(0, 255)) - 128;
        i3.ops[k*8 +: 8] = op[k][7:0];
      end
      i3.neg = 3'($urandom_range(0, 7));
      i3.sat = 1'($urandom_range(0, 1));
      i3.out_ready = (acc < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      chk("rand_in_ready", longint'(i3.in_ready), longint'(!i3.out_valid || i3.out_ready));
      if (i3.out_valid && i3.out_ready) begin
        got++;
        if (qf.size() == 0) begin
          chk("rand_extra_output", longint'(got), 0);
        end else begin
          fe = qf.pop_front(); oe = qo.pop_front();
          chk("rand_f", longint'($signed(i3.f)), fe);
          chk("rand_ovf", longint'(i3.ovf), oe);
        end
      end
      if (i3.in_valid && i3.in_ready) begin
        model(8, 3, op, 16'(i3.neg), i3.sat, fe, oe);
        qf.push_back(fe); qo.push_back(oe);
        acc++;
      end
      cyc++;
    end
    chk("rand_accepted", longint'(acc), 100);
    chk("rand_emitted", longint'(got), 100);
    chk("rand_queue_empty", longint'(qf.size()), 0);

    // three sets in flight, then reset: nothing may emerge afterwards
    @(posedge clk); #1;
    i3.out_ready = 1'b1; i3.neg = 3'b000; i3.sat = 1'b0; i3.in_valid = 1'b1;
    op[0] = 50; op[1] = 10; op[2] = 5;
    for (int k = 0; k < 3; k++) i3.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    op[0] = 20; op[1] = 20; op[2] = 20;
    for (int k = 0; k < 3; k++) i3.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    op[0] = 1; op[1] = 2; op[2] = 3;
    for (int k = 0; k < 3; k++) i3.ops[k*8 +: 8] = op[k][7:0];
    @(posedge clk); #1;
    i3.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(i3.out_valid), 0);
    chk("midrst_f", longint'(i3.f), 0);
    chk("midrst_ovf", longint'(i3.ovf), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (i3.out_valid) stale++;
    end
    chk("postrst_stale_outputs", longint'(stale), 0);

    op[0] = 7; op[1] = -3; op[2] = 4;
    model(8, 3, op, 16'b010, 1'b1, fe, oe);
    run3(op, 3'b010, 1'b1, fo, ov, lat);
    chk("postrst_f", fo, fe); chk("postrst_ovf", ov, oe); chk("postrst_latency", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
